fifo_serial_tx: RTL and testbench

FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

---
 rtl/fifo_serial_tx.sv | 132 +++++++++++++
 tb/tb_fifo_serial_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serial_tx.sv
// Serialises words pulled from an upstream FIFO into start/data/stop frames, MSB first.
// Outputs are registered copies of what the next state decodes to, so they line up with the state.
module fifo_serial_tx #(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned CNT_WIDTH    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic                  tx_out,
   output logic                  tx_busy,
   output logic                  word_done
);

   localparam int unsigned IDX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(CLKS_PER_BIT - 1);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      LOAD  = 3'd2,
      START = 3'd3,
      DATA  = 3'd4,
      STOP  = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [IDX_WIDTH-1:0]  idx_q, idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  bit_end;
   logic                  tx_d;
   logic                  busy_d;
   logic                  rd_en_d;
   logic                  done_d;

   assign bit_end = (cnt_q == LAST_CNT);

   // State, timing counter, bit index and payload registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   // Next state, datapath updates and next-cycle output values
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = 1'b1;
      busy_d  = 1'b0;
      rd_en_d = 1'b0;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (enable && !fifo_empty) state_d = REQ;
         end
         REQ: begin
            state_d = LOAD;
         end
         LOAD: begin
            shift_d = fifo_data;
            idx_d   = LAST_IDX;
            state_d = START;
         end
         START: begin
            if (bit_end) state_d = DATA;
            else         cnt_d   = cnt_q + CNT_WIDTH'(1);
         end
         DATA: begin
            if (bit_end) begin
               if (idx_q == '0) begin
                  state_d = STOP;
               end else begin
                  shift_d = shift_q << 1;
                  idx_d   = idx_q - IDX_WIDTH'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         STOP: begin
            if (bit_end) state_d = IDLE;
            else         cnt_d   = cnt_q + CNT_WIDTH'(1);
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d  = (state_d != IDLE);
      rd_en_d = (state_d == REQ);
      done_d  = (state_d == STOP) && (cnt_d == LAST_CNT);
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[DATA_WIDTH-1];
         default: tx_d = 1'b1;
      endcase
   end

   // Registered outputs; reset forces the line idle immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_out     <= 1'b1;
         fifo_rd_en <= 1'b0;
         tx_busy    <= 1'b0;
         word_done  <= 1'b0;
      end else begin
         tx_out     <= tx_d;
         fifo_rd_en <= rd_en_d;
         tx_busy    <= busy_d;
         word_done  <= done_d;
      end
   end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx with a small registered-read FIFO model upstream.
module tb_fifo_serial_tx;

   localparam int unsigned DW    = 16;
   localparam int unsigned CPB   = 4;
   localparam int unsigned FRAME = (DW + 2) * CPB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          fifo_empty;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_rd_en;
   logic          tx_out;
   logic          tx_busy;
   logic          word_done;

   logic [DW-1:0] fmem [0:7];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   int            total = 0;
   int            bad = 0;

   always #5 clk = ~clk;

   // Upstream FIFO: read data registered, valid the cycle after the request
   assign fifo_empty = (wr_ptr == rd_ptr);
   always @(posedge clk) begin
      if (fifo_rd_en && !fifo_empty) begin
         fifo_data <= fmem[rd_ptr[2:0]];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   fifo_serial_tx #(
      .DATA_WIDTH  (DW),
      .CLKS_PER_BIT(CPB),
      .CNT_WIDTH   (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .fifo_empty(fifo_empty),
      .fifo_data (fifo_data),
      .fifo_rd_en(fifo_rd_en),
      .tx_out    (tx_out),
      .tx_busy   (tx_busy),
      .word_done (word_done)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [FRAME-1:0] exp_wave(input logic [DW-1:0] w);
      logic [DW+1:0]    fr;
      logic [FRAME-1:0] r;
      logic             b;
      fr = {1'b0, w, 1'b1};
      r  = '0;
      for (int i = 0; i < int'(DW + 2); i++) begin
         b  = fr[DW+1];
         fr = fr << 1;
         r  = (r << CPB) | FRAME'({CPB{b}});
      end
      return r;
   endfunction

   task automatic push(input logic [DW-1:0] w);
      fmem[wr_ptr[2:0]] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   // Waits for the read request, then records every cycle of the frame (cycle 1 ends up in the MSB)
   task automatic run_frame(input int drop_at, input int rst_at,
                            output int wait_cyc, output logic [FRAME-1:0] wave,
                            output logic [FRAME-1:0] done_m, output logic [FRAME-1:0] busy_m,
                            output int rd_cnt, output logic empty_at_load,
                            output logic rst_tx, output logic rst_busy);
      logic found;
      wave = '0; done_m = '0; busy_m = '0; rd_cnt = 0; wait_cyc = 0;
      empty_at_load = 1'b0; rst_tx = 1'b0; rst_busy = 1'b1; found = 1'b0;
      while (wait_cyc < 200 && !found) begin
         @(negedge clk);
         wait_cyc++;
         found = fifo_rd_en;
      end
      if (!found) begin
         wait_cyc = -1;
         return;
      end
      rd_cnt = 1;
      @(negedge clk);
      empty_at_load = fifo_empty;
      if (fifo_rd_en) rd_cnt++;
      for (int c = 0; c < int'(FRAME); c++) begin
         @(negedge clk);
         if (c + 1 == rst_at) begin
            rst = 1'b1;
            #1;
            rst_tx   = tx_out;
            rst_busy = tx_busy;
            return;
         end
         if (c + 1 == drop_at) enable = 1'b0;
         wave   = {wave[FRAME-2:0], tx_out};
         done_m = {done_m[FRAME-2:0], word_done};
         busy_m = {busy_m[FRAME-2:0], tx_busy};
         if (fifo_rd_en) rd_cnt++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      enable = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL reset_tx_out: got %b want 1", tx_out); end
      total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
      total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
      total++; if (word_done !== 1'b0) begin bad++; $display("FAIL reset_word_done: got %b want 0", word_done); end
      rst = 1'b0;
   endtask

   task automatic test_idle();
      int rd_seen, tx_low, busy_seen;
      rd_seen = 0; tx_low = 0; busy_seen = 0;
      enable = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (fifo_rd_en) rd_seen++;
         if (!tx_out) tx_low++;
         if (tx_busy) busy_seen++;
      end
      total++; if (rd_seen !== 0) begin bad++; $display("FAIL idle_rd_en: got %0d cycles want 0", rd_seen); end
      total++; if (tx_low !== 0) begin bad++; $display("FAIL idle_tx_high: got %0d low cycles want 0", tx_low); end
      total++; if (busy_seen !== 0) begin bad++; $display("FAIL idle_busy: got %0d busy cycles want 0", busy_seen); end
   endtask

   task automatic test_single_word();
      int w, rd; logic [FRAME-1:0] wv, dm, bm; logic el, rt, rb;
      push(16'hFF01);
      run_frame(0, 0, w, wv, dm, bm, rd, el, rt, rb);
      total++; if (w !== 1) begin bad++; $display("FAIL single_req_latency: got %0d want 1", w); end
      total++; if (wv !== exp_wave(16'hFF01)) begin bad++; $display("FAIL single_wave: got %h want %h", wv, exp_wave(16'hFF01)); end
      total++; if (dm !== FRAME'(1)) begin bad++; $display("FAIL single_word_done: got %h want %h", dm, FRAME'(1)); end
      total++; if (bm !== '1) begin bad++; $display("FAIL single_busy: got %h want all ones", bm); end
      total++; if (rd !== 1) begin bad++; $display("FAIL single_rd_pulses: got %0d want 1", rd); end
      @(negedge clk);
      total++; if (tx_busy !== 1'b0 || tx_out !== 1'b1 || word_done !== 1'b0) begin
         bad++; $display("FAIL single_after_stop: busy=%b tx=%b done=%b want 0 1 0", tx_busy, tx_out, word_done);
      end
   endtask

   task automatic test_enable_drop();
      int w, rd, rd_seen, busy_seen; logic [FRAME-1:0] wv, dm, bm; logic el, rt, rb;
      enable = 1'b1;
      push(16'hABCD);
      run_frame(10, 0, w, wv, dm, bm, rd, el, rt, rb);
      total++; if (wv !== exp_wave(16'hABCD)) begin bad++; $display("FAIL drop_wave: got %h want %h", wv, exp_wave(16'hABCD)); end
      total++; if (dm !== FRAME'(1)) begin bad++; $display("FAIL drop_word_done: got %h want %h", dm, FRAME'(1)); end
      total++; if (bm !== '1) begin bad++; $display("FAIL drop_busy: got %h want all ones", bm); end
      @(negedge clk);
      push(16'h0F0F);
      rd_seen = 0; busy_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (fifo_rd_en) rd_seen++;
         if (tx_busy) busy_seen++;
      end
      total++; if (rd_seen !== 0 || busy_seen !== 0) begin
         bad++; $display("FAIL drop_no_req: rd=%0d busy=%0d want 0 0", rd_seen, busy_seen);
      end
      enable = 1'b1;
      run_frame(0, 0, w, wv, dm, bm, rd, el, rt, rb);
      total++; if (w !== 1) begin bad++; $display("FAIL drop_resume_latency: got %0d want 1", w); end
      total++; if (wv !== exp_wave(16'h0F0F)) begin bad++; $display("FAIL drop_resume_wave: got %h want %h", wv, exp_wave(16'h0F0F)); end
   endtask

   task automatic test_back_to_back();
      int wa, wb, rda, rdb, extra; logic [FRAME-1:0] wv, dm, bm, wv2, dm2, bm2; logic el, rt, rb;
      enable = 1'b0;
      push(16'h539E);
      push(16'h1100);
      @(negedge clk);
      enable = 1'b1;
      run_frame(0, 0, wa, wv, dm, bm, rda, el, rt, rb);
      run_frame(0, 0, wb, wv2, dm2, bm2, rdb, el, rt, rb);
      total++; if (wv !== exp_wave(16'h539E)) begin bad++; $display("FAIL b2b_wave1: got %h want %h", wv, exp_wave(16'h539E)); end
      total++; if (wv2 !== exp_wave(16'h1100)) begin bad++; $display("FAIL b2b_wave2: got %h want %h", wv2, exp_wave(16'h1100)); end
      total++; if (dm !== FRAME'(1) || dm2 !== FRAME'(1)) begin
         bad++; $display("FAIL b2b_word_done: got %h / %h want %h", dm, dm2, FRAME'(1));
      end
      // cycles strictly between word_done and the next START: IDLE, REQ, LOAD
      total++; if (wb + 1 !== 3) begin bad++; $display("FAIL b2b_gap: got %0d want 3", wb + 1); end
      extra = 0;
      repeat (10) begin
         @(negedge clk);
         if (fifo_rd_en) extra++;
      end
      total++; if (rda + rdb + extra !== 2) begin bad++; $display("FAIL b2b_rd_pulses: got %0d want 2", rda + rdb + extra); end
   endtask

   task automatic test_reset_mid();
      int w, rd, done_seen, busy_seen; logic [FRAME-1:0] wv, dm, bm; logic el, rt, rb;
      enable = 1'b1;
      push(16'h2222);
      run_frame(0, 30, w, wv, dm, bm, rd, el, rt, rb);
      total++; if (rt !== 1'b1) begin bad++; $display("FAIL rstmid_tx_out: got %b want 1", rt); end
      total++; if (rb !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", rb); end
      done_seen = 0; busy_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (word_done) done_seen++;
         if (tx_busy) busy_seen++;
      end
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (word_done) done_seen++;
         if (tx_busy) busy_seen++;
      end
      total++; if (done_seen !== 0) begin bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_seen); end
      total++; if (busy_seen !== 0) begin bad++; $display("FAIL rstmid_no_start: got %0d busy cycles want 0", busy_seen); end
      push(16'h3C5A);
      run_frame(0, 0, w, wv, dm, bm, rd, el, rt, rb);
      total++; if (w !== 1) begin bad++; $display("FAIL rstmid_fresh_latency: got %0d want 1", w); end
      total++; if (wv !== exp_wave(16'h3C5A)) begin bad++; $display("FAIL rstmid_fresh_wave: got %h want %h", wv, exp_wave(16'h3C5A)); end
      total++; if (dm !== FRAME'(1)) begin bad++; $display("FAIL rstmid_fresh_done: got %h want %h", dm, FRAME'(1)); end
   endtask

   task automatic test_fifo_integration();
      int wa, wb, rda, rdb; logic [FRAME-1:0] wv, dm, bm, wv2, dm2, bm2; logic ela, elb, rt, rb;
      enable = 1'b1;
      push(16'h5050);
      push(16'h1111);
      run_frame(0, 0, wa, wv, dm, bm, rda, ela, rt, rb);
      run_frame(0, 0, wb, wv2, dm2, bm2, rdb, elb, rt, rb);
      total++; if (wv !== exp_wave(16'h5050)) begin bad++; $display("FAIL fifo_wave1: got %h want %h", wv, exp_wave(16'h5050)); end
      total++; if (wv2 !== exp_wave(16'h1111)) begin bad++; $display("FAIL fifo_wave2: got %h want %h", wv2, exp_wave(16'h1111)); end
      total++; if (ela !== 1'b0) begin bad++; $display("FAIL fifo_empty_after_rd1: got %b want 0", ela); end
      total++; if (elb !== 1'b1) begin bad++; $display("FAIL fifo_empty_after_rd2: got %b want 1", elb); end
      total++; if (rda + rdb !== 2) begin bad++; $display("FAIL fifo_rd_pulses: got %0d want 2", rda + rdb); end
      @(negedge clk);
      total++; if (tx_busy !== 1'b0 || tx_out !== 1'b1) begin
         bad++; $display("FAIL fifo_final_idle: busy=%b tx=%b want 0 1", tx_busy, tx_out);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single_word();
      test_enable_drop();
      test_back_to_back();
      test_reset_mid();
      test_fifo_integration();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
